blackbox_stim_checker: RTL and testbench

Self-checking stimulus/response stage that sits directly upstream and downstream of a black-box device under test. It drives a pseudo-random vector stream into the DUT input and compares the DUT output against a delayed copy of the same stream after a fixed latency. It reports pass/fail, the mismatch count and the index of the first failing vector. It replaces the single-constant, single-assert harness pattern with a multi-vector, latency-aware checker that can be reused across passthrough black boxes.

---
 rtl/blackbox_stim_checker_pkg.sv | 14 +
 rtl/blackbox_stim_checker_if.sv | 14 +
 rtl/blackbox_stim_checker_expect_delay.sv | 47 ++++
 rtl/blackbox_stim_checker.sv | 100 ++++++++++
 tb/tb_blackbox_stim_checker.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/blackbox_stim_checker_pkg.sv
// checker_pkg: shared FSM encodings, LFSR constants and step function for blackbox_stim_checker
package checker_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] NO_ERR    = 16'hFFFF;

    // Fibonacci x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/blackbox_stim_checker_if.sv
// blackbox_stim_checker_if: stimulus/response bus between checker (master) and black-box DUT (slave)
//   stim_data  : vector driven into the DUT input
//   stim_valid : stim_data carries a live vector this cycle
//   resp_data  : DUT output returned to the checker
interface blackbox_stim_checker_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] stim_data;
    logic             stim_valid;
    logic [WIDTH-1:0] resp_data;

    modport master (output stim_data, output stim_valid, input resp_data);
    modport slave  (input stim_data, input stim_valid, output resp_data);
endinterface

// File: rtl/blackbox_stim_checker_expect_delay.sv
// expect_delay: LATENCY-deep delay of the expected {valid, data, idx}; depth 0 is a pass-through
//   clock/reset          : rising-edge clock, async active-low reset (clears valid bits only)
//   in_valid/data/idx    : expected payload entering the line
//   out_valid/data/idx   : payload delayed by DEPTH cycles
module expect_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [15:0]      in_idx,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      out_idx
);
    if (DEPTH == 0) begin : g_pass
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign out_idx   = in_idx;
    end else begin : g_pipe
        logic [DEPTH-1:0] v_q;
        logic [WIDTH-1:0] d_q [DEPTH];
        logic [15:0]      i_q [DEPTH];
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                v_q <= '0;
            end else begin
                v_q[0] <= in_valid;
                for (int i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1];
            end
        end
        // payload is qualified by the valid bit, so it needs no reset
        always_ff @(posedge clock) begin
            d_q[0] <= in_data;
            i_q[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                d_q[i] <= d_q[i-1];
                i_q[i] <= i_q[i-1];
            end
        end
        assign out_valid = v_q[DEPTH-1];
        assign out_data  = d_q[DEPTH-1];
        assign out_idx   = i_q[DEPTH-1];
    end
endmodule

// File: rtl/blackbox_stim_checker.sv
// blackbox_stim_checker: drives LFSR vectors into a black-box DUT and checks its latency-aligned response
//   clock/reset   : rising-edge clock, async active-low reset
//   start         : one-cycle run request (accepted in IDLE or DONE)
//   bus           : stim_data/stim_valid out to DUT, resp_data back
//   busy/done/pass: run in progress / run complete (held) / complete without mismatches
//   err_count     : saturating mismatch count; first_err_idx: first failing vector or 16'hFFFF
module blackbox_stim_checker
    import checker_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          LATENCY     = 0,
    parameter int          NUM_VECTORS = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          CW          = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    blackbox_stim_checker_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CW-1:0]          err_count,
    output logic [15:0]            first_err_idx
);
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    logic [1:0]       state;
    logic [15:0]      lfsr;
    logic [15:0]      vec_idx;
    logic [3:0]       drain_cnt;
    logic [WIDTH-1:0] hold_data;
    logic             armed;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic [15:0]      exp_idx;
    logic             go;
    logic             mismatch;

    assign busy           = (state == ST_RUN) || (state == ST_DRAIN);
    assign done           = state == ST_DONE;
    assign pass           = done && (err_count == '0);
    assign bus.stim_valid = state == ST_RUN;
    assign bus.stim_data  = bus.stim_valid ? lfsr[WIDTH-1:0] : hold_data;
    // armed stays low for the first edge after reset release so a coincident start is dropped
    assign go             = armed && start && (state == ST_IDLE || state == ST_DONE);
    assign mismatch       = busy && exp_valid && (bus.resp_data != exp_data);

    expect_delay #(.WIDTH(WIDTH), .DEPTH(LATENCY)) u_expect_delay (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (bus.stim_valid),
        .in_data   (bus.stim_data),
        .in_idx    (vec_idx),
        .out_valid (exp_valid),
        .out_data  (exp_data),
        .out_idx   (exp_idx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            lfsr      <= SEED;
            vec_idx   <= '0;
            drain_cnt <= '0;
            hold_data <= '0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (go) begin
                state   <= ST_RUN;
                lfsr    <= SEED;
                vec_idx <= '0;
            end else if (state == ST_RUN) begin
                hold_data <= lfsr[WIDTH-1:0];
                lfsr      <= lfsr_step(lfsr);
                vec_idx   <= vec_idx + 1'b1;
                drain_cnt <= '0;
                if (vec_idx == LAST_IDX) state <= LATENCY > 0 ? ST_DRAIN : ST_DONE;
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
                if (drain_cnt == LAST_DRAIN) state <= ST_DONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count     <= '0;
            first_err_idx <= NO_ERR;
        end else if (go) begin
            err_count     <= '0;
            first_err_idx <= NO_ERR;
        end else if (mismatch) begin
            err_count     <= (err_count == '1) ? err_count : err_count + 1'b1;
            first_err_idx <= (first_err_idx == NO_ERR) ? exp_idx : first_err_idx;
        end
    end
endmodule

// File: tb/tb_blackbox_stim_checker.sv
// tb_blackbox_stim_checker: directed runs of four checker configurations against small DUT models
module tb_blackbox_stim_checker;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic mode  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    blackbox_stim_checker_if #(.WIDTH(8)) b0 ();
    blackbox_stim_checker_if #(.WIDTH(8)) b1 ();
    blackbox_stim_checker_if #(.WIDTH(8)) b2 ();
    blackbox_stim_checker_if #(.WIDTH(8)) b3 ();

    logic        busy [4];
    logic        done [4];
    logic        pass [4];
    logic [7:0]  err  [3];
    logic [1:0]  err3;
    logic [15:0] fidx [4];

    blackbox_stim_checker #(.LATENCY(0)) u0 (
        .clock(clock), .reset(reset), .start(start), .bus(b0), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err[0]), .first_err_idx(fidx[0]));
    blackbox_stim_checker #(.LATENCY(3)) u1 (
        .clock(clock), .reset(reset), .start(start), .bus(b1), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err[1]), .first_err_idx(fidx[1]));
    blackbox_stim_checker #(.LATENCY(2)) u2 (
        .clock(clock), .reset(reset), .start(start), .bus(b2), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(err[2]), .first_err_idx(fidx[2]));
    blackbox_stim_checker #(.LATENCY(0), .CW(2)) u3 (
        .clock(clock), .reset(reset), .start(start), .bus(b3), .busy(busy[3]), .done(done[3]),
        .pass(pass[3]), .err_count(err3), .first_err_idx(fidx[3]));

    // DUT models: wire/invert, 3-stage register, 2-stage register corrupting vector 5, invert
    assign b0.resp_data = mode ? ~b0.stim_data : b0.stim_data;

    logic [7:0] p1 [3];
    always @(posedge clock) begin
        p1[0] <= b1.stim_data;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign b1.resp_data = p1[2];

    int vcnt = 0;
    logic [7:0] p2 [2];
    always @(posedge clock) begin
        vcnt  <= b2.stim_valid ? vcnt + 1 : (busy[2] ? vcnt : 0);
        p2[0] <= (b2.stim_valid && vcnt == 5) ? (b2.stim_data | 8'h01) : b2.stim_data;
        p2[1] <= p2[0];
    end
    assign b2.resp_data = p2[1];

    assign b3.resp_data = ~b3.stim_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_stim_valid"}, b0.stim_valid, 0);
        check({tag, "_stim_data"}, b0.stim_data, 0);
        check({tag, "_busy"}, busy[1], 0);
        check({tag, "_done"}, done[0], 0);
        check({tag, "_pass"}, pass[0], 0);
        check({tag, "_err3"}, err3, 0);
        check({tag, "_fidx"}, fidx[3], 16'hFFFF);
    endtask

    int d0, d1, vfirst, vlast, nv1;
    logic [7:0] cur [$];
    logic [7:0] seq_a [$];
    logic [7:0] seq_b [$];

    // call at a negedge; that cycle is cycle 0 of the run
    task automatic run(input bit pulses);
        d0 = 0; d1 = 0; vfirst = 0; vlast = 0; nv1 = 0;
        cur.delete();
        start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clock);
            if (done[0] && d0 == 0) d0 = c;
            if (done[1] && d1 == 0) d1 = c;
            if (b1.stim_valid) begin
                nv1++;
                if (vfirst == 0) vfirst = c;
                vlast = c;
            end
            if (b3.stim_valid) cur.push_back(b3.stim_data);
            if (pulses && (c == 3 || c == 10)) check($sformatf("busy_at_pulse_c%0d", c), busy[3], 1);
            start = pulses && (c == 3 || c == 10);
        end
        start = 1'b0;
    endtask

    logic [7:0] exp_vec [6] = '{8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C};

    initial begin
        repeat (2) @(negedge clock);
        check_reset_state("por");
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_at_release_ignored", busy[0], 0);
        repeat (2) @(negedge clock);

        mode = 1'b0;
        run(1'b1);
        seq_a = cur;
        check("wire_done_cycle", d0, 17);
        check("wire_pass", pass[0], 1);
        check("wire_err", err[0], 0);
        check("wire_fidx", fidx[0], 16'hFFFF);
        check("lat3_done_cycle", d1, 20);
        check("lat3_pass", pass[1], 1);
        check("lat3_valid_count", nv1, 16);
        check("lat3_valid_first", vfirst, 1);
        check("lat3_valid_last", vlast, 16);
        check("lat2_err", err[2], 1);
        check("lat2_fidx", fidx[2], 5);
        check("lat2_pass", pass[2], 0);
        check("cw2_err_sat", err3, 3);
        check("cw2_fidx", fidx[3], 0);
        check("cw2_pass", pass[3], 0);
        check("seq_a_len", seq_a.size(), 16);
        for (int i = 0; i < 6; i++) check($sformatf("vec%0d", i), seq_a[i], exp_vec[i]);

        mode = 1'b1;
        run(1'b0);
        seq_b = cur;
        check("inv_done_cycle", d0, 17);
        check("inv_err", err[0], 16);
        check("inv_fidx", fidx[0], 0);
        check("inv_pass", pass[0], 0);
        check("rerun_lat3_pass", pass[1], 1);
        check("seq_b_len", seq_b.size(), 16);
        for (int i = 0; i < 16 && i < seq_a.size() && i < seq_b.size(); i++)
            check($sformatf("repeat_vec%0d", i), seq_b[i], seq_a[i]);

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("mid_busy_before_reset", busy[0], 1);
        reset = 1'b0;
        #1;
        check_reset_state("midrun");
        check("midrun_lat3_busy", busy[1], 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        mode = 1'b0;
        run(1'b0);
        check("post_reset_done_cycle", d0, 17);
        check("post_reset_pass", pass[0], 1);
        check("post_reset_err", err[0], 0);
        check("post_reset_fidx", fidx[0], 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
